scan_sequencer: RTL and testbench

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

---
 rtl/scan_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_scan_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/scan_sequencer.sv
// -----------------------------------------------------------------------------
// scan_sequencer
//
// Steps a 3-to-8 decoder through its channels. Each channel gets a blanking
// phase (decoder disabled) of `blank` cycles followed by an active phase
// (decoder enabled) of max(dwell,1) cycles. A full pass over the channel list
// ends with a one-cycle frame_done pulse as the first channel is re-entered.
//
// Optional feature macro: SCAN_SKIP_EN
//   undefined : channels 0..7 visited in order, mask ignored.
//   defined   : only channels whose mask bit is set are visited, ascending;
//               mask is re-sampled at every advance point, mask=0 stops.
//
// Ports
//   clk        : clock, all state changes on rising edge
//   rst_n      : asynchronous active-low reset
//   start      : level request to begin scanning (honoured only in IDLE)
//   stop       : level request to end scanning
//   dwell      : active cycles per channel (0 treated as 1)
//   blank      : blanking cycles before each channel
//   mask       : channel enable bits (SCAN_SKIP_EN builds only)
//   sel        : channel index to the decoder
//   dis        : decoder disable (1 = all decoder outputs low)
//   busy       : high whenever not IDLE
//   frame_done : one-cycle pulse on re-entry of the first channel
// -----------------------------------------------------------------------------
module scan_sequencer #(
    parameter int DWELL_W = 8,
    parameter int BLANK_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [BLANK_W-1:0] blank,
    input  logic [7:0]         mask,
    output logic [2:0]         sel,
    output logic               dis,
    output logic               busy,
    output logic               frame_done
);

    localparam int CNT_W = (DWELL_W > BLANK_W) ? DWELL_W : BLANK_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BLANK  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [2:0]         sel_reg, sel_next;
    logic               stop_pend_reg, stop_pend_next;
    logic               armed_reg;
    logic               dis_reg, dis_next;
    logic               busy_reg, busy_next;
    logic               fd_reg, fd_next;

    // Channel list helpers
    logic [2:0]         first_ch;
    logic [2:0]         next_ch;
    logic               wrap;
    logic               has_any;

    // Phase load values: counter runs down to zero, so load length-1
    logic [CNT_W-1:0]   blank_load;
    logic [CNT_W-1:0]   dwell_load;
    state_t             enter_state;
    logic [CNT_W-1:0]   enter_cnt;

    assign blank_load  = CNT_W'(blank) - CNT_W'(1);
    assign dwell_load  = (dwell == '0) ? '0 : (CNT_W'(dwell) - CNT_W'(1));
    assign enter_state = (blank != '0) ? ST_BLANK : ST_ACTIVE;
    assign enter_cnt   = (blank != '0) ? blank_load : dwell_load;

`ifdef SCAN_SKIP_EN
    logic [2:0] next_up;
    logic       found_up;

    // Descending scan so the lowest qualifying index is the last one written
    always_comb begin
        first_ch = 3'd0;
        next_up  = 3'd0;
        found_up = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) begin
                first_ch = 3'(i);
            end
            if (mask[i] && (3'(i) > sel_reg)) begin
                next_up  = 3'(i);
                found_up = 1'b1;
            end
        end
        has_any = |mask;
        next_ch = found_up ? next_up : first_ch;
        wrap    = ~found_up;
    end
`else
    logic unused_mask;
    assign unused_mask = ^mask;
    assign first_ch    = 3'd0;
    assign has_any     = 1'b1;
    assign next_ch     = sel_reg + 3'd1;
    assign wrap        = (sel_reg == 3'd7);
`endif

    // State register (all outputs come straight from flops)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            sel_reg       <= 3'd0;
            stop_pend_reg <= 1'b0;
            armed_reg     <= 1'b0;
            dis_reg       <= 1'b1;
            busy_reg      <= 1'b0;
            fd_reg        <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            sel_reg       <= sel_next;
            stop_pend_reg <= stop_pend_next;
            armed_reg     <= 1'b1;
            dis_reg       <= dis_next;
            busy_reg      <= busy_next;
            fd_reg        <= fd_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        sel_next       = sel_reg;
        stop_pend_next = stop_pend_reg;
        fd_next        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // armed_reg keeps the first edge after reset release quiet
                if (start && !stop && armed_reg && has_any) begin
                    state_next = enter_state;
                    cnt_next   = enter_cnt;
                    sel_next   = first_ch;
                end
            end
            ST_BLANK: begin
                if (stop) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == '0) begin
                    state_next = ST_ACTIVE;
                    cnt_next   = dwell_load;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            ST_ACTIVE: begin
                // A stop seen at any point in the active phase is honoured
                // once the phase has run its full length.
                stop_pend_next = stop_pend_reg | stop;
                if (cnt_reg == '0) begin
                    stop_pend_next = 1'b0;
                    if (stop || stop_pend_reg || !has_any) begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end else begin
                        state_next = enter_state;
                        cnt_next   = enter_cnt;
                        sel_next   = next_ch;
                        fd_next    = wrap;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Output decode of the upcoming state, registered above
    always_comb begin
        dis_next  = (state_next != ST_ACTIVE);
        busy_next = (state_next != ST_IDLE);
    end

    assign sel        = sel_reg;
    assign dis        = dis_reg;
    assign busy       = busy_reg;
    assign frame_done = fd_reg;

endmodule

// File: tb/tb_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_scan_sequencer
//
// Directed bench for scan_sequencer. Inputs change 1 time unit after a rising
// edge; outputs are sampled at the same point. Expected values are computed
// from the phase lengths of each directed scenario.
// -----------------------------------------------------------------------------
module tb_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [7:0] dwell;
    logic [3:0] blank;
    logic [7:0] mask;
    logic [2:0] sel;
    logic       dis;
    logic       busy;
    logic       frame_done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    scan_sequencer #(
        .DWELL_W(8),
        .BLANK_W(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .dwell      (dwell),
        .blank      (blank),
        .mask       (mask),
        .sel        (sel),
        .dis        (dis),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int e_sel, input int e_dis,
                              input int e_busy, input int e_fd);
        $display("%s: sel=%0d dis=%0d busy=%0d frame_done=%0d (exp %0d %0d %0d %0d)",
                 tag, sel, dis, busy, frame_done, e_sel, e_dis, e_busy, e_fd);
        check({tag, ".sel"},  32'(sel),        32'(e_sel));
        check({tag, ".dis"},  32'(dis),        32'(e_dis));
        check({tag, ".busy"}, 32'(busy),       32'(e_busy));
        check({tag, ".fd"},   32'(frame_done), 32'(e_fd));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        dwell = 8'd3;
        blank = 4'd2;
`ifdef SCAN_SKIP_EN
        mask  = 8'hFF;
`else
        mask  = 8'h00;
`endif
        #2 rst_n = 1'b0;
        #1;
        expect_out("reset", 0, 1, 0, 0);
        step();
        rst_n = 1'b1;
        step();
        expect_out("post_release", 0, 1, 0, 0);

        // dwell=3, blank=2: 5 cycles per channel, frame_done at edge 41
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 42; k++) begin
            if (k > 1) step();
            expect_out($sformatf("scan_d3b2 k=%0d", k), ((k - 1) / 5) % 8,
                       (((k - 1) % 5) < 2) ? 1 : 0, 1, (k == 41) ? 1 : 0);
        end
        // edge 42 left us in BLANK of channel 0: stop there is immediate
        stop = 1'b1;
        step();
        stop = 1'b0;
        expect_out("stop_in_blank", 0, 1, 0, 0);

        // dwell=0, blank=0: sel moves every cycle, decoder stays enabled
        dwell = 8'd0;
        blank = 4'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) step();
            expect_out($sformatf("scan_d0b0 k=%0d", k), (k - 1) % 8, 0, 1,
                       (k == 9) ? 1 : 0);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        expect_out("stop_d0", 1, 1, 0, 0);

        // dwell=4, blank=0, start held high throughout (ignored while busy);
        // stop raised on the 2nd active cycle of channel 5 (edge 22)
        dwell = 8'd4;
        start = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            step();
            expect_out($sformatf("scan_d4 k=%0d", k), (k - 1) / 4, 0, 1, 0);
        end
        stop = 1'b1;
        step();
        expect_out("stop_active k=23", 5, 0, 1, 0);
        step();
        expect_out("stop_active k=24", 5, 0, 1, 0);
        step();
        expect_out("stop_active k=25", 5, 1, 0, 0);
        // start and stop both high while IDLE: stop wins
        step();
        expect_out("start_and_stop", 5, 1, 0, 0);
        start = 1'b0;
        stop  = 1'b0;

        // Asynchronous reset in the middle of an active phase
        dwell = 8'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        expect_out("pre_async_reset", 1, 0, 1, 0);
        rst_n = 1'b0;
        #1;
        expect_out("async_reset", 0, 1, 0, 0);
        // start held through release: first edge after release stays idle
        start = 1'b1;
        #2 rst_n = 1'b1;
        step();
        expect_out("first_edge_after_release", 0, 1, 0, 0);
        step();
        expect_out("start_after_release", 0, 0, 1, 0);
        start = 1'b0;

`ifdef SCAN_SKIP_EN
        // mask 1010_0100, blank=1, dwell=2: 3 cycles per channel, 2,5,7,2
        do_reset();
        mask  = 8'b1010_0100;
        blank = 4'd1;
        dwell = 8'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            int seq_sel;
            if (k > 1) step();
            case (((k - 1) / 3) % 3)
                0:       seq_sel = 2;
                1:       seq_sel = 5;
                default: seq_sel = 7;
            endcase
            expect_out($sformatf("skip k=%0d", k), seq_sel,
                       (((k - 1) % 3) == 0) ? 1 : 0, 1, (k == 10) ? 1 : 0);
        end
        do_reset();
        mask  = 8'h00;
        start = 1'b1;
        step();
        step();
        expect_out("mask_zero_start", 0, 1, 0, 0);
        start = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
